// File: rtl/ps2_host_transmitter_if.sv
// Command handshake between a PS/2 host controller and its frame transmitter.
// The controller owns the master side; the transmitter owns the slave side.
interface ps2_host_transmitter_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_err;

   modport master (
      output tx_data,
      output tx_start,
      input  tx_busy,
      input  tx_done,
      input  tx_err
   );

   modport slave (
      input  tx_data,
      input  tx_start,
      output tx_busy,
      output tx_done,
      output tx_err
   );
endinterface

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-bit frame
// shifted on device clocks, ACK check, single-cycle done/error report.
module ps2_host_transmitter #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 1500000,
   parameter int FILTER_LEN     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   ps2_host_transmitter_if.slave bus,
   inout  wire                  io_ps2_clk,
   inout  wire                  io_ps2_data
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_ONE  = {{(INH_W-1){1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic [INH_W-1:0] INH_ZERO = {INH_W{1'b0}};
   localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_RTS       = 3'd2,
      S_SEND      = 3'd3,
      S_ACK       = 3'd4,
      S_WAIT_IDLE = 3'd5,
      S_DONE      = 3'd6,
      S_ERR       = 3'd7
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_clk_sync;
   logic [1:0]            r_data_sync;
   logic [FILTER_LEN-1:0] r_flt_hist;
   logic [FILTER_LEN-1:0] w_flt_hist_nxt;
   logic                  r_clk_filt;
   logic                  w_clk_filt_nxt;
   logic                  r_fall;
   logic [8:0]            r_shreg;
   logic [8:0]            w_shreg_nxt;
   logic [3:0]            r_bit_cnt;
   logic [3:0]            w_bit_cnt_nxt;
   logic [INH_W-1:0]      r_inh_cnt;
   logic [INH_W-1:0]      w_inh_cnt_nxt;
   logic [TMO_W-1:0]      r_tmo;
   logic [TMO_W-1:0]      w_tmo_nxt;
   logic                  r_clk_oe;
   logic                  r_data_oe;
   logic                  w_data_oe_nxt;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;
   logic                  w_tmo_hit;
   logic                  w_data_in;

   function automatic logic f_odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   assign io_ps2_clk  = r_clk_oe  ? 1'b0 : 1'bz;
   assign io_ps2_data = r_data_oe ? 1'b0 : 1'bz;

   assign bus.tx_busy = r_busy;
   assign bus.tx_done = r_done;
   assign bus.tx_err  = r_err;

   assign w_data_in = r_data_sync[1];
   assign w_tmo_hit = (r_tmo == TMO_LAST);

   // Two-flop synchronisers; an idle bus reads high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], io_ps2_clk};
         r_data_sync <= {r_data_sync[0], io_ps2_data};
      end
   end

   // Clock level only moves after FILTER_LEN identical samples
   always_comb begin
      w_flt_hist_nxt = {r_flt_hist[FILTER_LEN-2:0], r_clk_sync[1]};
      if (&w_flt_hist_nxt) begin
         w_clk_filt_nxt = 1'b1;
      end else if (~|w_flt_hist_nxt) begin
         w_clk_filt_nxt = 1'b0;
      end else begin
         w_clk_filt_nxt = r_clk_filt;
      end
   end

   // Filter history, filtered level and falling-edge strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flt_hist <= {FILTER_LEN{1'b1}};
         r_clk_filt <= 1'b1;
         r_fall     <= 1'b0;
      end else begin
         r_flt_hist <= w_flt_hist_nxt;
         r_clk_filt <= w_clk_filt_nxt;
         r_fall     <= r_clk_filt & ~w_clk_filt_nxt;
      end
   end

   // Next-state and datapath updates
   always_comb begin
      w_state_nxt   = r_state;
      w_shreg_nxt   = r_shreg;
      w_bit_cnt_nxt = r_bit_cnt;
      w_inh_cnt_nxt = r_inh_cnt;
      w_tmo_nxt     = r_tmo;
      w_data_oe_nxt = r_data_oe;
      case (r_state)
         S_IDLE: begin
            w_data_oe_nxt = 1'b0;
            if (bus.tx_start) begin
               w_state_nxt   = S_INHIBIT;
               w_shreg_nxt   = {1'b1, f_odd_parity(bus.tx_data), bus.tx_data};
               w_inh_cnt_nxt = INH_ZERO;
            end else begin
               w_state_nxt   = S_IDLE;
            end
         end
         S_INHIBIT: begin
            if (r_inh_cnt == INH_LAST) begin
               w_state_nxt   = S_RTS;
               w_data_oe_nxt = 1'b1;
            end else begin
               w_inh_cnt_nxt = r_inh_cnt + INH_ONE;
            end
         end
         S_RTS: begin
            w_state_nxt   = S_SEND;
            w_bit_cnt_nxt = 4'd0;
            w_tmo_nxt     = TMO_ZERO;
            w_data_oe_nxt = 1'b1;
         end
         S_SEND: begin
            w_tmo_nxt = r_tmo + TMO_ONE;
            // A timeout wins over a fall arriving in the same cycle
            if (w_tmo_hit) begin
               w_state_nxt   = S_ERR;
               w_data_oe_nxt = 1'b0;
            end else if (r_bit_cnt == 4'd10) begin
               w_state_nxt   = S_ACK;
            end else if (r_fall) begin
               w_data_oe_nxt = ~r_shreg[0];
               w_shreg_nxt   = {1'b0, r_shreg[8:1]};
               w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end else begin
               w_state_nxt   = S_SEND;
            end
         end
         S_ACK: begin
            w_tmo_nxt     = r_tmo + TMO_ONE;
            w_data_oe_nxt = 1'b0;
            if (w_tmo_hit) begin
               w_state_nxt = S_ERR;
            end else if (r_fall) begin
               w_state_nxt = w_data_in ? S_ERR : S_WAIT_IDLE;
            end else begin
               w_state_nxt = S_ACK;
            end
         end
         S_WAIT_IDLE: begin
            w_tmo_nxt     = r_tmo + TMO_ONE;
            w_data_oe_nxt = 1'b0;
            if (w_tmo_hit) begin
               w_state_nxt = S_ERR;
            end else if (r_clk_filt && w_data_in) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_WAIT_IDLE;
            end
         end
         S_DONE: begin
            w_state_nxt   = S_IDLE;
            w_data_oe_nxt = 1'b0;
         end
         S_ERR: begin
            w_state_nxt   = S_IDLE;
            w_data_oe_nxt = 1'b0;
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_data_oe_nxt = 1'b0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and outputs, registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg   <= 9'h000;
         r_bit_cnt <= 4'd0;
         r_inh_cnt <= INH_ZERO;
         r_tmo     <= TMO_ZERO;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_inh_cnt <= w_inh_cnt_nxt;
         r_tmo     <= w_tmo_nxt;
         r_clk_oe  <= (w_state_nxt == S_INHIBIT) || (w_state_nxt == S_RTS);
         r_data_oe <= w_data_oe_nxt;
         r_busy    <= w_state_nxt inside {S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE};
         r_done    <= (w_state_nxt == S_DONE);
         r_err     <= (w_state_nxt == S_ERR);
      end
   end

endmodule
